// File: rtl/add_pkg.sv
// Shared definitions for the pipelined add/subtract unit: result flags,
// operation encoding, and helpers that turn WIDTH/CHUNK into a stage count.
package add_pkg;

    // Flags produced alongside the sum by the final stage
    typedef struct packed {
        logic co;
        logic ov;
        logic z;
    } flags_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of carry-pipelined stages; never below one so arrays stay sized
    function automatic int calc_stages(input int width, input int chunk);
        int n;
        if (chunk > 0) begin
            n = width / chunk;
        end else begin
            n = 1;
        end
        if (n < 1) begin
            n = 1;
        end
        return n;
    endfunction

    // WIDTH must split evenly into chunks no wider than the operand
    function automatic bit params_legal(input int width, input int chunk);
        return (chunk > 0) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/add_chunk_stage.sv
// One CHUNK-bit slice of the carry-pipelined adder. Registers its partial
// sum, carry-out, the overflow flag of its MSB and the beat valid bit; all
// state holds while en is low (downstream stall).
module add_chunk_stage #(
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             prev_valid,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum_s,
    output logic [CHUNK-1:0] sum_r,
    output logic             co_r,
    output logic             ov_r,
    output logic             valid_r
);

    logic [CHUNK:0] total_s;
    logic           msb_cin_s;

    // Slice addition; carry into the MSB is recovered from the MSB sum bit
    always_comb begin
        total_s   = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        sum_s     = total_s[CHUNK-1:0];
        msb_cin_s = total_s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end

    // Slice result register with synchronous clear and stall hold
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r   <= '0;
            co_r    <= 1'b0;
            ov_r    <= 1'b0;
            valid_r <= 1'b0;
        end else if (en) begin
            sum_r   <= sum_s;
            co_r    <= total_s[CHUNK];
            ov_r    <= msb_cin_s ^ total_s[CHUNK];
            valid_r <= prev_valid;
        end
    end

endmodule

// File: rtl/add_pipe.sv
// WIDTH-bit add/subtract unit built from STAGES carry-pipelined CHUNK-bit
// slices. Operand chunks are skewed in, sum chunks de-skewed out, so one
// beat per cycle emerges with a fixed latency of STAGES cycles. A single
// global enable freezes the whole pipe while the consumer stalls.
module add_pipe
    import add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OV,
    output logic             Z
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (!params_legal(WIDTH, CHUNK)) begin : g_bad_params
        $error("add_pipe: WIDTH must be a non-zero multiple of CHUNK and CHUNK <= WIDTH");
    end

    logic             en_s;
    logic [WIDTH-1:0] beff_s;
    logic             ceff_s;
    logic [WIDTH-1:0] s_next_s;
    logic             z_r;
    flags_t           flags_s;

    logic [CHUNK-1:0] stage_sum_s   [STAGES];
    logic [CHUNK-1:0] stage_sum_r   [STAGES];
    logic             stage_co_r    [STAGES];
    logic             stage_ov_r    [STAGES];
    logic             stage_valid_r [STAGES];

    // Global stall, operand conditioning for subtract, and flag bundle
    always_comb begin
        in_ready = !stage_valid_r[STAGES-1] || out_ready;
        en_s     = in_ready;
        if (sub == OP_SUB) begin
            beff_s = ~B;
            ceff_s = ~CI;
        end else begin
            beff_s = B;
            ceff_s = CI;
        end
        flags_s.co = stage_co_r[STAGES-1];
        flags_s.ov = stage_ov_r[STAGES-1];
        flags_s.z  = z_r;
    end

    assign out_valid = stage_valid_r[STAGES-1];
    assign CO        = flags_s.co;
    assign OV        = flags_s.ov;
    assign Z         = flags_s.z;

    for (genvar j = 0; j < STAGES; j++) begin : g_chunk
        localparam int DEPTH = STAGES - 1 - j;

        logic [CHUNK-1:0] a_op_s;
        logic [CHUNK-1:0] b_op_s;
        logic             cin_s;
        logic             vld_s;

        if (j == 0) begin : g_head
            assign a_op_s = A[CHUNK-1:0];
            assign b_op_s = beff_s[CHUNK-1:0];
            assign cin_s  = ceff_s;
            assign vld_s  = in_valid;
        end else begin : g_skew
            logic [CHUNK-1:0] a_dly_r [j];
            logic [CHUNK-1:0] b_dly_r [j];

            // Delay this operand chunk so it meets the carry from below
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < j; k++) begin
                        a_dly_r[k] <= '0;
                        b_dly_r[k] <= '0;
                    end
                end else if (en_s) begin
                    a_dly_r[0] <= A[j*CHUNK +: CHUNK];
                    b_dly_r[0] <= beff_s[j*CHUNK +: CHUNK];
                    for (int k = 1; k < j; k++) begin
                        a_dly_r[k] <= a_dly_r[k-1];
                        b_dly_r[k] <= b_dly_r[k-1];
                    end
                end
            end

            assign a_op_s = a_dly_r[j-1];
            assign b_op_s = b_dly_r[j-1];
            assign cin_s  = stage_co_r[j-1];
            assign vld_s  = stage_valid_r[j-1];
        end

        add_chunk_stage #(.CHUNK(CHUNK)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .en         (en_s),
            .prev_valid (vld_s),
            .a          (a_op_s),
            .b          (b_op_s),
            .cin        (cin_s),
            .sum_s      (stage_sum_s[j]),
            .sum_r      (stage_sum_r[j]),
            .co_r       (stage_co_r[j]),
            .ov_r       (stage_ov_r[j]),
            .valid_r    (stage_valid_r[j])
        );

        if (DEPTH == 0) begin : g_top_chunk
            assign S[j*CHUNK +: CHUNK]        = stage_sum_r[j];
            assign s_next_s[j*CHUNK +: CHUNK] = stage_sum_s[j];
        end else begin : g_deskew
            logic [CHUNK-1:0] s_dly_r [DEPTH];

            // Hold finished low chunks until the top chunk catches up
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        s_dly_r[k] <= '0;
                    end
                end else if (en_s) begin
                    s_dly_r[0] <= stage_sum_r[j];
                    for (int k = 1; k < DEPTH; k++) begin
                        s_dly_r[k] <= s_dly_r[k-1];
                    end
                end
            end

            assign S[j*CHUNK +: CHUNK] = s_dly_r[DEPTH-1];

            if (DEPTH == 1) begin : g_next_direct
                assign s_next_s[j*CHUNK +: CHUNK] = stage_sum_r[j];
            end else begin : g_next_chain
                assign s_next_s[j*CHUNK +: CHUNK] = s_dly_r[DEPTH-2];
            end
        end
    end

    // Zero flag registered together with the final sum chunk
    always_ff @(posedge clk) begin
        if (rst) begin
            z_r <= 1'b0;
        end else if (en_s) begin
            z_r <= (s_next_s == {WIDTH{1'b0}});
        end
    end

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe (WIDTH=16, CHUNK=4): directed corner
// vectors, throughput under stall, reset mid-flight, then random traffic
// scored against an arithmetic reference model.
module tb_add_pipe;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        CI;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        CO;
    logic        OV;
    logic        Z;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   out_cnt = 0;
    int   last_xfer = 0;
    exp_t exp_q[$];

    add_pipe #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .CI        (CI),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .CO        (CO),
        .OV        (OV),
        .Z         (Z)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: exact integer arithmetic, flags from range checks
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic op);
        exp_t   e;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint uc = longint'(ci);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        longint sr;
        if (op) begin
            r    = ua - ub - uc;
            sr   = sa - sb - uc;
            e.co = (r >= 0);
        end else begin
            r    = ua + ub + uc;
            sr   = sa + sb + uc;
            e.co = (r >= 65536);
        end
        e.s  = r[15:0];
        e.ov = (sr < -32768) || (sr > 32767);
        e.z  = (e.s == 16'h0000);
        return e;
    endfunction

    // Scoreboard: predict on input transfer, compare on output transfer
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("S", 32'(S), 32'(e.s));
                    check("CO", 32'(CO), 32'(e.co));
                    check("OV", 32'(OV), 32'(e.ov));
                    check("Z", 32'(Z), 32'(e.z));
                end
                out_cnt++;
                last_xfer = cyc + 1;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(A, B, CI, sub));
            end
        end
    end

    // One beat into an idle pipe: latency and literal expected results
    task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic ci,
                            input logic op, input logic [15:0] es, input logic eco,
                            input logic eov, input logic ez);
        int n;
        @(posedge clk); #1;
        A = a; B = b; CI = ci; sub = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("latency", 32'(n), 32'd4);
        check("dir_S", 32'(S), 32'(es));
        check("dir_CO", 32'(CO), 32'(eco));
        check("dir_OV", 32'(OV), 32'(eov));
        check("dir_Z", 32'(Z), 32'(ez));
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int          base;
        int          c0;
        int          n;
        logic [15:0] s0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = 16'h0000; B = 16'h0000; CI = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_S", 32'(S), 32'd0);
        check("rst_CO", 32'(CO), 32'd0);
        check("rst_OV", 32'(OV), 32'd0);
        check("rst_Z", 32'(Z), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        directed(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);
        directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed(16'h0009, 16'h0009, 1'b1, 1'b0, 16'h0013, 1'b0, 1'b0, 1'b0);
        directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        directed(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0);

        // Throughput with a three-cycle consumer stall
        @(posedge clk); #1;
        base = out_cnt;
        c0 = cyc;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    logic acc;
                    int   guard;
                    A = 16'(i); B = 16'(i); CI = 1'b0; sub = 1'b0; in_valid = 1'b1;
                    guard = 0;
                    do begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk); #1;
                        guard++;
                    end while (!acc && guard < 40);
                end
                in_valid = 1'b0;
            end
            begin
                int k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!out_valid && k < 30);
                check("tp_first_valid", 32'(out_valid), 32'd1);
                s0 = S;
                check("stall_in_ready", 32'(in_ready), 32'd0);
                for (int i = 0; i < 2; i++) begin
                    @(posedge clk); #1;
                    check("stall_S", 32'(S), 32'(s0));
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
                k = 0;
                while (out_cnt < base + 6 && k < 60) begin
                    @(negedge clk);
                    k++;
                end
            end
        join
        check("tp_count", 32'(out_cnt - base), 32'd6);
        check("tp_cycles", 32'(last_xfer - c0), 32'd13);
        repeat (3) @(posedge clk);

        // Reset with three beats in flight
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            A = 16'($urandom); B = 16'($urandom); CI = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_S", 32'(S), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        base = out_cnt;
        repeat (10) @(negedge clk);
        check("mid_rst_dropped", 32'(out_cnt - base), 32'd0);
        directed(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

        // Random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            A   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            B   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            CI  = 1'($urandom);
            sub = 1'($urandom);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("drain_idle", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
